// File: rtl/definesPkg.sv
// definesPkg: shared address/data/coherence types for the writeback buffer slice.
// The address is split into a 4-bit page reference and an 8-bit address code,
// so {page 1, code 0x10} reads as the flat 12-bit address 0x110.
package definesPkg;

    localparam int WB_DEPTH = 4;
    localparam int PAGE_W   = 4;
    localparam int CODE_W   = 8;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [PAGE_W-1:0] Page_reference;
        logic [CODE_W-1:0] Address_code;
    } Taddress;

    typedef logic [DATA_W-1:0] Tdata_sb;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } Tmesi_state;

    // Buffer slot index; wraps naturally at WB_DEPTH.
    typedef logic [1:0] Tptr;

endpackage

// File: rtl/wb_entry_cam.sv
// wb_entry_cam: compares a read address against every live buffer slot in
// parallel. Slots are scanned oldest to youngest starting at the head, so the
// last hit found is the most recently pushed copy of that address.
module wb_entry_cam
    import definesPkg::*;
(
    input  Taddress               entry_addr [WB_DEPTH],
    input  logic [WB_DEPTH-1:0]   entry_valid,
    input  Tptr                   head,
    input  Taddress               rd_addr,
    output logic                  hit,
    output Tptr                   youngest_idx
);

    Tptr idx;

    // Age-ordered scan; full-struct compare covers page and code fields.
    always_comb begin
        hit          = 1'b0;
        youngest_idx = head;
        idx          = head;
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = head + Tptr'(k);
            if (entry_valid[idx] && (entry_addr[idx] == rd_addr)) begin
                hit          = 1'b1;
                youngest_idx = idx;
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: holds dirty evictions in a small FIFO and drains them to
// memory in the background, giving cache-miss reads priority unless the read
// hits a buffered address.
// Optional feature: define WB_READ_FORWARD_EN to answer hazard reads straight
// from the buffer (youngest match) instead of draining before the read.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | choose between starting a read and draining the head entry
// DRAIN    | write head entry to memory, pop it at end of cycle
// RD_ISSUE | present rd_addr to memory with we=0
// RD_WAIT  | memory data valid; return it with a one-cycle rd_ack
module writeback_buffer
    import definesPkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       evict_valid,
    output logic       evict_ready,
    input  Taddress    evict_addr,
    input  Tdata_sb    evict_data,
    input  Tmesi_state evict_mesi,
    input  logic       rd_req,
    input  Taddress    rd_addr,
    output logic       rd_ack,
    output Tdata_sb    rd_data,
    output Taddress    addr,
    output Tdata_sb    wdata,
    output logic       we,
    input  Tdata_sb    rdata,
    input  Tmesi_state mesi_state_in,
    output Tmesi_state mesi_state_out,
    output logic       empty,
    output logic       full
);

    typedef enum logic [1:0] {IDLE, DRAIN, RD_ISSUE, RD_WAIT} wb_state_t;

    wb_state_t           state, state_next;
    Taddress             buf_addr [WB_DEPTH];
    Tdata_sb             buf_data [WB_DEPTH];
    Tptr                 wr_ptr, rd_ptr;
    logic [2:0]          count;
    logic [WB_DEPTH-1:0] entry_valid;
    logic                push, pop, hazard, rd_pending;
    Tptr                 youngest;

    // Memory never reports coherence state back to this block.
    logic unused_mesi_in;
    assign unused_mesi_in = ^mesi_state_in;

    assign empty       = (count == 3'd0);
    assign full        = (count == 3'(WB_DEPTH));
    assign evict_ready = !full;
    // Clean evictions are handshaken but never stored.
    assign push        = evict_valid && evict_ready && (evict_mesi == MODIFIED);
    assign pop         = (state == DRAIN);

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            entry_valid[i] = ({1'b0, Tptr'(i) - rd_ptr} < count);
        end
    end

    wb_entry_cam u_cam (
        .entry_addr   (buf_addr),
        .entry_valid  (entry_valid),
        .head         (rd_ptr),
        .rd_addr      (rd_addr),
        .hit          (hazard),
        .youngest_idx (youngest)
    );

`ifdef WB_READ_FORWARD_EN
    logic    fwd_ack, fwd_take;
    Tdata_sb fwd_data;

    // A request being acked this cycle must not be accepted a second time.
    assign rd_pending = rd_req && !fwd_ack;
    assign fwd_take   = (state == IDLE) && rd_pending && hazard;

    // Capture the youngest buffered copy; ack it the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_ack  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_ack <= fwd_take;
            if (fwd_take) begin
                fwd_data <= buf_data[youngest];
            end
        end
    end
`else
    logic unused_youngest;
    assign unused_youngest = ^youngest;
    assign rd_pending      = rd_req;
`endif

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= evict_addr;
            buf_data[wr_ptr] <= evict_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop nets to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + Tptr'(1);
            if (pop)  rd_ptr <= rd_ptr + Tptr'(1);
            count <= count + 3'(push) - 3'(pop);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: clean reads first, hazards force drains (or forward).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_pending && !hazard) begin
                    state_next = RD_ISSUE;
`ifdef WB_READ_FORWARD_EN
                end else if (rd_pending && hazard) begin
                    state_next = IDLE;
`endif
                end else if (!empty) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:    state_next = IDLE;
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; held quiet while reset is asserted.
    always_comb begin
        we             = 1'b0;
        addr           = '0;
        wdata          = '0;
        mesi_state_out = INVALID;
        rd_ack         = 1'b0;
        rd_data        = '0;
        if (!reset) begin
            case (state)
                DRAIN: begin
                    we             = 1'b1;
                    addr           = buf_addr[rd_ptr];
                    wdata          = buf_data[rd_ptr];
                    mesi_state_out = MODIFIED;
                end
                RD_ISSUE: addr = rd_addr;
                RD_WAIT: begin
                    rd_ack  = 1'b1;
                    rd_data = rdata;
                end
                default: ;
            endcase
`ifdef WB_READ_FORWARD_EN
            if (fwd_ack) begin
                rd_ack  = 1'b1;
                rd_data = fwd_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer. The reference model is a queue of
// pending dirty lines plus a "latest value per address" table: every read must
// return the most recent MODIFIED value pushed, or the memory's initial word.
module tb_writeback_buffer;
    import definesPkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       evict_valid, evict_ready;
    Taddress    evict_addr;
    Tdata_sb    evict_data;
    Tmesi_state evict_mesi;
    logic       rd_req, rd_ack;
    Taddress    rd_addr;
    Tdata_sb    rd_data;
    Taddress    addr;
    Tdata_sb    wdata;
    logic       we;
    Tdata_sb    rdata;
    Tmesi_state mesi_state_in, mesi_state_out;
    logic       empty, full;

    writeback_buffer dut (
        .clk(clk), .reset(reset),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_addr(evict_addr), .evict_data(evict_data), .evict_mesi(evict_mesi),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
        .mesi_state_in(mesi_state_in), .mesi_state_out(mesi_state_out),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    bit acc_flag = 1'b0;

    typedef struct {
        logic [11:0] a;
        Tdata_sb     d;
    } ent_t;
    ent_t    q[$];
    Tdata_sb latest   [4096];
    bit      latest_v [4096];

    function automatic Tdata_sb init_val(input logic [11:0] a);
        if (a == 12'h005) return 32'h1234_5678;
        return 32'hC0DE_0000 ^ {20'h0, a} ^ ({20'h0, a} << 16);
    endfunction

    function automatic Tdata_sb expect_read(input logic [11:0] a);
        return latest_v[a] ? latest[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: registered read, one cycle after the address is presented.
    Tdata_sb     mem   [4096];
    bit          mem_v [4096];
    logic [11:0] ma, ea;
    assign ma = addr;
    assign ea = evict_addr;
    always @(posedge clk) begin
        if (we) begin
            mem[ma]   <= wdata;
            mem_v[ma] <= 1'b1;
        end
        rdata <= mem_v[ma] ? mem[ma] : init_val(ma);
    end

    // Monitor: status vs model occupancy, drains vs FIFO head, push tracking.
    always @(negedge clk) begin : mon
        int n;
        if (reset) begin
            q.delete();
            acc_flag = 1'b0;
        end else begin
            n = q.size();
            check("empty", {31'h0, empty}, {31'h0, n == 0});
            check("full", {31'h0, full}, {31'h0, n == WB_DEPTH});
            check("evict_ready", {31'h0, evict_ready}, {31'h0, n < WB_DEPTH});
            if (we) begin
                we_cnt++;
                check("drain_addr", {20'h0, addr}, (n > 0) ? {20'h0, q[0].a} : 32'hFFFF_FFFF);
                if (n > 0) check("drain_data", wdata, q[0].d);
                check("drain_mesi", {30'h0, mesi_state_out}, {30'h0, MODIFIED});
                if (n > 0) void'(q.pop_front());
            end else begin
                check("idle_mesi", {30'h0, mesi_state_out}, {30'h0, INVALID});
            end
            acc_flag = evict_valid && (n < WB_DEPTH);
            if (acc_flag && evict_mesi == MODIFIED) begin
                q.push_back('{ea, evict_data});
                latest[ea]   = evict_data;
                latest_v[ea] = 1'b1;
            end
        end
    end

    // Offer one eviction; returns one cycle-offset after the accepting edge.
    task automatic push(input logic [11:0] a, input Tdata_sb d, input Tmesi_state m);
        bit got = 1'b0;
        evict_addr  = Taddress'(a);
        evict_data  = d;
        evict_mesi  = m;
        evict_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_flag) begin
                got = 1'b1;
                break;
            end
        end
        check("push_accept", {31'h0, got}, 32'h1);
        evict_valid = 1'b0;
    endtask

    // we_rule: 0 ignore, 1 no memory write allowed, 2 a drain must precede ack.
    task automatic do_read(input logic [11:0] a, input int exp_lat, input int we_rule, input string tag);
        Tdata_sb exp, got_data;
        bit      got = 1'b0;
        int      lat = 0;
        int      w0;
        exp      = expect_read(a);
        got_data = '0;
        w0       = we_cnt;
        rd_addr  = Taddress'(a);
        rd_req   = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                got      = 1'b1;
                lat      = i;
                got_data = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
        #1;
        check({tag, "_ack"}, {31'h0, got}, 32'h1);
        check({tag, "_data"}, got_data, exp);
        if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
        if (we_rule == 1) check({tag, "_no_we"}, we_cnt - w0, 0);
        if (we_rule == 2) check({tag, "_drained"}, {31'h0, (we_cnt - w0) > 0}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (empty && q.size() == 0) break;
        end
        check("drained_all", q.size(), 0);
    endtask

    initial begin
        logic [11:0] pool [8];
        bit          seen;
        int          lat, w0;
        pool = '{12'h040, 12'h041, 12'h140, 12'h240, 12'h0C3, 12'h3C3, 12'h050, 12'h0F0};

        reset = 1'b1;
        evict_valid = 1'b0; evict_addr = '0; evict_data = '0; evict_mesi = INVALID;
        rd_req = 1'b0; rd_addr = '0; mesi_state_in = INVALID;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", {31'h0, empty}, 32'h1);
        check("rst_full", {31'h0, full}, 32'h0);
        check("rst_we", {31'h0, we}, 32'h0);
        check("rst_rd_ack", {31'h0, rd_ack}, 32'h0);
        check("rst_addr", {20'h0, addr}, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_mesi", {30'h0, mesi_state_out}, {30'h0, INVALID});
        reset = 1'b0;
        @(posedge clk); #1;

        // Single dirty eviction drains on the cycle after it lands.
        push(12'h110, 32'hDEAD_BEEF, MODIFIED);
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (we) begin
                seen = 1'b1; lat = i;
                check("first_drain_addr", {20'h0, addr}, 32'h110);
                check("first_drain_data", wdata, 32'hDEAD_BEEF);
                break;
            end
        end
        check("first_drain_seen", {31'h0, seen}, 32'h1);
        check("first_drain_latency", lat, 2);
        @(posedge clk); #1;
        check("first_drain_empty", {31'h0, empty}, 32'h1);

        // Clean eviction is dropped.
        w0 = we_cnt;
        push(12'h230, 32'h0BAD_0BAD, SHARED);
        repeat (4) @(posedge clk);
        #1;
        check("shared_no_we", we_cnt - w0, 0);
        check("shared_empty", {31'h0, empty}, 32'h1);

        // Clean miss goes to memory with fixed latency.
        do_read(12'h005, 3, 1, "miss_read");

        // Read of a buffered address.
        push(12'h020, 32'hA5A5_A5A5, MODIFIED);
`ifdef WB_READ_FORWARD_EN
        do_read(12'h020, 2, 1, "hazard_fwd");
`else
        do_read(12'h020, 0, 2, "hazard_stall");
`endif
        wait_empty();

        // Continuous clean reads starve drains until the buffer fills.
        rd_addr = Taddress'(12'h7FF);
        rd_req  = 1'b1;
        push(12'h301, 32'h1111_0001, MODIFIED);
        push(12'h302, 32'h1111_0002, MODIFIED);
        push(12'h303, 32'h1111_0003, MODIFIED);
        push(12'h304, 32'h1111_0004, MODIFIED);
        @(negedge clk);
        check("fill_full", {31'h0, full}, 32'h1);
        check("fill_not_ready", {31'h0, evict_ready}, 32'h0);
        evict_addr = Taddress'(12'h305); evict_data = 32'h1111_0005;
        evict_mesi = MODIFIED; evict_valid = 1'b1;
        w0 = we_cnt;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                seen = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        check("fill_read_ack", {31'h0, seen}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (acc_flag) begin
                seen = 1'b1;
                break;
            end
        end
        evict_valid = 1'b0;
        check("fifth_accepted", {31'h0, seen}, 32'h1);
        check("fifth_after_drain", {31'h0, (we_cnt - w0) > 0}, 32'h1);
        wait_empty();

        // Randomized mix of evictions, reads and idle gaps.
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r <= 1) begin
                push(pool[$urandom_range(0, 7)], $urandom, Tmesi_state'($urandom_range(0, 3)));
            end else if (r == 2) begin
                do_read(pool[$urandom_range(0, 7)], 0, 0, "rand_read");
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_empty();

        // Reset while a read is in its data cycle with two entries buffered.
        rd_addr = Taddress'(12'h0AA);
        rd_req  = 1'b1;
        evict_addr = Taddress'(12'h411); evict_data = 32'h4444_0011;
        evict_mesi = MODIFIED; evict_valid = 1'b1;
        @(posedge clk); #1;
        evict_addr = Taddress'(12'h412); evict_data = 32'h4444_0012;
        @(posedge clk); #1;
        evict_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_no_ack", {31'h0, rd_ack}, 32'h0);
        @(posedge clk); #1;
        rd_req = 1'b0;
        check("rst_mid_empty", {31'h0, empty}, 32'h1);
        check("rst_mid_ack", {31'h0, rd_ack}, 32'h0);
        check("rst_mid_we", {31'h0, we}, 32'h0);
        reset = 1'b0;
        w0 = we_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_discard", we_cnt - w0, 0);
        do_read(12'h0AA, 3, 1, "post_rst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have ports evict_valid in 1, evict_ready out 1, evict_addr in Taddress, evict_data in Tdata_sb, evict_mesi in Tmesi_state: cache eviction push.
REQ-004 SHALL have ports rd_req in 1, rd_addr in Taddress, rd_ack out 1, rd_data out Tdata_sb: cache miss read.
REQ-005 SHALL have ports addr out Taddress, wdata out Tdata_sb, we out 1, rdata in Tdata_sb, mesi_state_in in Tmesi_state, mesi_state_out out Tmesi_state: main memory side.
REQ-006 SHALL have ports empty out 1, full out 1: status.

Function
REQ-007 SHALL hold WB_DEPTH (4) entries {addr, data}, FIFO order; 2-bit wrapping read/write pointers, 3-bit count.
REQ-008 Push SHALL occur when evict_valid && evict_ready && evict_mesi==MODIFIED; evict_ready = !full.
REQ-009 Evictions with evict_mesi != MODIFIED SHALL be accepted (when ready) and discarded.
REQ-010 FSM states: IDLE, DRAIN, RD_ISSUE, RD_WAIT.
REQ-011 IDLE: rd_req pending and no hazard -> RD_ISSUE; else !empty -> DRAIN; else stay.
REQ-012 DRAIN: one cycle; we=1, addr/wdata = head entry, mesi_state_out=MODIFIED; head popped at end of cycle; -> IDLE.
REQ-013 RD_ISSUE: we=0, addr=rd_addr; -> RD_WAIT. RD_WAIT: rd_data=rdata, rd_ack=1 for one cycle; -> IDLE.
REQ-014 Read latency from memory SHALL be 2 cycles after rd_req accepted in IDLE; rd_req SHALL be held until rd_ack.
REQ-015 Hazard: rd_addr equal to any valid entry; without forwarding, reads SHALL stall and DRAIN runs until no match.
REQ-016 Reads SHALL have priority over drains when no hazard.
REQ-017 Push and pop in same cycle SHALL leave count unchanged; push when full SHALL not occur (evict_ready=0).
REQ-018 mesi_state_out SHALL be INVALID whenever we=0.
REQ-019 Address compare SHALL cover both Page_reference and Address_code fields.

Reset
REQ-020 On reset: state IDLE, pointers/count 0, empty=1, full=0, we=0, rd_ack=0, addr=0, wdata=0, rd_data=0, mesi_state_out=INVALID.
REQ-021 Reset mid-drain or mid-read SHALL discard all entries and abort without asserting rd_ack.

Configuration
REQ-022 Macro WB_READ_FORWARD_EN: when defined, a hazard read SHALL return youngest matching entry's data with rd_ack in the cycle after rd_req, no memory access.
REQ-023 Without WB_READ_FORWARD_EN, REQ-015 stall behaviour SHALL apply.

Structure
REQ-024 Taddress, Tdata_sb, Tmesi_state, WB_DEPTH SHALL come from definesPkg; FSM state enum local.
REQ-025 Sub-module wb_entry_cam (parallel match of rd_addr against entries, returns hit and youngest index) SHALL be used.

Verification
REQ-026 Push MODIFIED {page 1, code 0x10, data 0xDEADBEEF}, idle -> next cycle we=1, addr=0x110, wdata 0xDEADBEEF, then empty=1.
REQ-027 Push 4 MODIFIED with reads stalled -> full=1, evict_ready=0; fifth held, accepted after first drain.
REQ-028 Push SHARED eviction -> no we pulse, empty stays 1.
REQ-029 rd_req to non-buffered 0x005 with memory word 0x12345678 -> rd_ack 2 cycles later, rd_data 0x12345678.
REQ-030 Buffer 0x020=0xA5A5A5A5, rd_req 0x020 -> with macro: rd_ack next cycle, 0xA5A5A5A5, no we; without: drain write then read returns 0xA5A5A5A5.
REQ-031 Assert reset during RD_WAIT with 2 entries -> no rd_ack, empty=1, FSM IDLE.
